// File: rtl/rv_pkg.sv
// Shared core types and defaults for the integer register file.
// Bypass option: define REGFILE_BYPASS_EN.
package rv_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = $clog2(DEF_NREG);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] word_t;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: issue sets, write-back clears, flush wins.
// Register 0 is never marked busy.
module reg_scoreboard
    import rv_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            flush,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            iss_ok;
    logic            wr_ok;

    assign iss_ok = iss_en && (iss_addr != AW'(ZERO_REG));
    assign wr_ok  = wr_en && (wr_addr != AW'(ZERO_REG));

    // Issue is applied after the clear so a colliding newer producer stays busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with NRD read ports and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward write-back data to reads.
module reg_file_sb
    import rv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic            wr_ok;

    assign wr_ok = wr_en && (wr_addr != AW'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_ok && (wr_addr == AW'(i))) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    reg_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .busy     (busy)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            logic [AW-1:0] ra;
            logic          hit;
            ra  = rd_addr[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            hit = wr_ok && (wr_addr == ra);
`else
            hit = 1'b0;
`endif
            if (ra != AW'(ZERO_REG)) begin
                if (hit) begin
                    rd_data[p*XLEN +: XLEN] = wr_data;
                    rd_busy[p]              = 1'b0;
                end else begin
                    rd_data[p*XLEN +: XLEN] = regs[ra];
                    rd_busy[p]              = busy[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised and directed check of reg_file_sb against an array model.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    always #5 clk = ~clk;

    reg_file_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge on the model.
    task automatic model_update();
        if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
        if (flush) begin
            for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        end else begin
            if (wr_en && wr_addr != 0) m_busy[wr_addr] = 1'b0;
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic compare();
        for (int p = 0; p < NRD; p++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] ed;
            logic            eb;
            a = rd_addr[p*AW +: AW];
            if (a == 0) begin
                ed = '0;
                eb = 1'b0;
            end else if (BYP && wr_en && wr_addr == a) begin
                ed = wr_data;
                eb = 1'b0;
            end else begin
                ed = m_regs[a];
                eb = m_busy[a];
            end
            chk($sformatf("data p%0d x%0d", p, a), rd_data[p*XLEN +: XLEN], ed);
            chk($sformatf("busy p%0d x%0d", p, a), 32'(rd_busy[p]), 32'(eb));
        end
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        iss_en = 0; iss_addr = 0; flush = 0;
    endtask

    task automatic set_all(input logic [AW-1:0] a);
        for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = a;
    endtask

    task automatic cyc();
        #1 compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        set_all(5'd0);
        model_reset();
        @(negedge clk);
        #1;
        chk("reset data p0", rd_data[31:0], 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // x0 protection
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
        iss_en = 1; iss_addr = 0;
        cyc();
        idle();
        set_all(5'd0);
        #1;
        for (int p = 0; p < NRD; p++) begin
            chk("x0 data", rd_data[p*XLEN +: XLEN], 32'h0);
            chk("x0 busy", 32'(rd_busy[p]), 32'h0);
        end

        // write then read
        wr_en = 1; wr_addr = 7; wr_data = 32'h12345678;
        set_all(5'd7);
        #1;
        chk("x7 same cycle", rd_data[31:0], BYP ? 32'h12345678 : 32'h0);
        cyc();
        idle();
        #1;
        chk("x7 p0", rd_data[31:0], 32'h12345678);
        chk("x7 p1", rd_data[63:32], 32'h12345678);

        // scoreboard life of x3
        iss_en = 1; iss_addr = 3;
        cyc();
        idle();
        set_all(5'd3);
        #1;
        chk("x3 busy after issue", 32'(rd_busy[0]), 32'h1);
        wr_en = 1; wr_addr = 3; wr_data = 32'hA5A5A5A5;
        #1;
        chk("x3 wb busy", 32'(rd_busy[0]), BYP ? 32'h0 : 32'h1);
        chk("x3 wb data", rd_data[31:0], BYP ? 32'hA5A5A5A5 : 32'h0);
        cyc();
        idle();
        #1;
        chk("x3 after busy", 32'(rd_busy[0]), 32'h0);
        chk("x3 after data", rd_data[31:0], 32'hA5A5A5A5);

        // issue / write-back collision
        iss_en = 1; iss_addr = 9;
        wr_en = 1; wr_addr = 9; wr_data = 32'h55;
        cyc();
        idle();
        set_all(5'd9);
        #1;
        chk("x9 data", rd_data[31:0], 32'h55);
        chk("x9 busy", 32'(rd_busy[0]), 32'h1);

        // flush beats a same-cycle issue
        iss_en = 1; iss_addr = 1; cyc();
        iss_en = 1; iss_addr = 2; cyc();
        iss_en = 1; iss_addr = 31; cyc();
        iss_en = 1; iss_addr = 4; flush = 1; cyc();
        idle();
        for (int k = 0; k < 4; k++) begin
            logic [AW-1:0] fa;
            fa = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : (k == 2) ? 5'd31 : 5'd4;
            set_all(fa);
            #1 chk($sformatf("flush x%0d", fa), 32'(rd_busy[0]), 32'h0);
        end

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 3) != 0);
            wr_en    = ($urandom_range(0, 2) != 0);
            wr_addr  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wr_data  = $urandom;
            iss_en   = ($urandom_range(0, 2) != 0);
            iss_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            flush    = ($urandom_range(0, 24) == 0);
            for (int p = 0; p < NRD; p++) begin
                rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? wr_addr :
                    (narrow ? AW'($urandom_range(0, 7)) : AW'($urandom));
            end
            cyc();
        end
        idle();

        // asynchronous reset mid-cycle
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        cyc();
        idle();
        iss_en = 1; iss_addr = 5;
        cyc();
        idle();
        set_all(5'd5);
        #1;
        chk("x5 before reset", rd_data[31:0], 32'hDEADBEEF);
        chk("x5 busy before reset", 32'(rd_busy[0]), 32'h1);
        wr_en = 1; wr_addr = 6; wr_data = 32'h77;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int p = 0; p < NRD; p++) begin
            chk("x5 reset data", rd_data[p*XLEN +: XLEN], 32'h0);
            chk("x5 reset busy", 32'(rd_busy[p]), 32'h0);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        set_all(5'd6);
        #1 chk("x6 discarded", rd_data[31:0], 32'h0);
        rst_n = 1'b1;
        wr_en = 1; wr_addr = 6; wr_data = 32'h99;
        cyc();
        idle();
        #1 chk("x6 after reset", rd_data[31:0], 32'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
